wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage.sv | 138 +++++++++++++
 tb/tb_wb_stage.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Write-back stage: commits ALU results and load data to the register file,
// stalls upstream while a load is outstanding and flags load timeouts.
// Optional feature macro: WB_RETIRE_COUNT_EN enables the retired_count counter;
// when undefined, retired_count is tied to zero.
module wb_stage #(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned ADDR_W       = 3,
    parameter int unsigned LOAD_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_inst,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [ADDR_W-1:0] in_dest_addr,
    input  logic              in_reg_write,
    input  logic              in_mem_to_reg,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic              stall,
    output logic              wb_wr_en,
    output logic [ADDR_W-1:0] wb_address,
    output logic [DATA_W-1:0] wb_data,
    output logic              fwd_valid,
    output logic [ADDR_W-1:0] fwd_addr,
    output logic [DATA_W-1:0] fwd_data,
    output logic [DATA_W-1:0] inst_out,
    output logic              load_err,
    output logic [15:0]       retired_count
);

    localparam int unsigned CNT_W = (LOAD_TIMEOUT < 2) ? 1 : $clog2(LOAD_TIMEOUT);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(LOAD_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOAD = 2'd1,
        COMMIT    = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   wait_cnt;
    logic [ADDR_W-1:0]  pend_addr;
    logic [DATA_W-1:0]  pend_inst;

    logic can_accept;
    logic take_alu;
    logic take_load;
    logic load_done;

    // Entry classification; a non-writing entry retires even if flagged as a load
    assign can_accept = (state == IDLE) || (state == COMMIT);
    assign take_alu   = can_accept && in_valid && in_reg_write && !in_mem_to_reg;
    assign take_load  = can_accept && in_valid && in_reg_write && in_mem_to_reg;
    assign load_done  = (state == WAIT_LOAD) && mem_rvalid;

    // Stall rises in the cycle a load is accepted and holds while waiting for data
    assign stall = !rst && ((state == WAIT_LOAD) || take_load);

    // Forwarding path mirrors the registered commit
    assign fwd_valid = wb_wr_en;
    assign fwd_addr  = wb_address;
    assign fwd_data  = wb_data;

    // Stage FSM with registered commit outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            pend_addr  <= '0;
            pend_inst  <= '0;
            wb_wr_en   <= 1'b0;
            wb_address <= '0;
            wb_data    <= '0;
            inst_out   <= '0;
            load_err   <= 1'b0;
        end else begin
            wb_wr_en <= 1'b0;
            case (state)
                IDLE, COMMIT: begin
                    if (take_alu) begin
                        state      <= COMMIT;
                        wb_wr_en   <= 1'b1;
                        wb_address <= in_dest_addr;
                        wb_data    <= in_alu_result;
                        inst_out   <= in_inst;
                    end else if (take_load) begin
                        state     <= WAIT_LOAD;
                        pend_addr <= in_dest_addr;
                        pend_inst <= in_inst;
                        wait_cnt  <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT_LOAD: begin
                    // Data arriving on the final waiting cycle still wins over the timeout
                    if (mem_rvalid) begin
                        state      <= COMMIT;
                        wb_wr_en   <= 1'b1;
                        wb_address <= pend_addr;
                        wb_data    <= mem_rdata;
                        inst_out   <= pend_inst;
                    end else if (wait_cnt == LAST_WAIT) begin
                        state    <= IDLE;
                        load_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WB_RETIRE_COUNT_EN
    logic        take_retire;
    logic        retire_now;
    logic [15:0] retire_cnt;

    assign take_retire = can_accept && in_valid && !in_reg_write;
    assign retire_now  = take_alu || load_done || take_retire;

    // Retired-instruction counter, wraps naturally at 16 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_cnt <= '0;
        end else if (retire_now) begin
            retire_cnt <= retire_cnt + 16'd1;
        end
    end

    assign retired_count = retire_cnt;
`else
    assign retired_count = 16'd0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus a randomized
// transaction stream checked against a transaction-level expected write list.
module tb_wb_stage;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned TMO    = 15;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid;
    logic [DATA_W-1:0] in_inst;
    logic [DATA_W-1:0] in_alu_result;
    logic [ADDR_W-1:0] in_dest_addr;
    logic              in_reg_write;
    logic              in_mem_to_reg;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rvalid;
    logic              stall;
    logic              wb_wr_en;
    logic [ADDR_W-1:0] wb_address;
    logic [DATA_W-1:0] wb_data;
    logic              fwd_valid;
    logic [ADDR_W-1:0] fwd_addr;
    logic [DATA_W-1:0] fwd_data;
    logic [DATA_W-1:0] inst_out;
    logic              load_err;
    logic [15:0]       retired_count;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] i;
    } wr_t;

    wr_t obs_q[$];
    wr_t exp_q[$];
    bit  mon_en = 1'b0;

    wb_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LOAD_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_inst(in_inst), .in_alu_result(in_alu_result),
        .in_dest_addr(in_dest_addr), .in_reg_write(in_reg_write),
        .in_mem_to_reg(in_mem_to_reg), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .stall(stall), .wb_wr_en(wb_wr_en), .wb_address(wb_address), .wb_data(wb_data),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .inst_out(inst_out), .load_err(load_err), .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    // Expected counter value depends on whether the counter is built in
    function automatic logic [15:0] exp_count(input int n);
`ifdef WB_RETIRE_COUNT_EN
        return 16'(n);
`else
        return 16'd0;
`endif
    endfunction

    // Record every write the register file would see
    always @(posedge clk) begin
        if (mon_en && wb_wr_en) obs_q.push_back({wb_address, wb_data, inst_out});
    end

    // Forwarding outputs must always mirror the write port
    always @(negedge clk) begin
        checks++;
        if ({fwd_valid, fwd_addr, fwd_data} !== {wb_wr_en, wb_address, wb_data}) begin
            failures++;
            $display("FAIL fwd_mirror t=%0t got=%b/%h/%h exp=%b/%h/%h", $time,
                     fwd_valid, fwd_addr, fwd_data, wb_wr_en, wb_address, wb_data);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid      = 1'b0;
        in_inst       = '0;
        in_alu_result = '0;
        in_dest_addr  = '0;
        in_reg_write  = 1'b0;
        in_mem_to_reg = 1'b0;
        mem_rdata     = '0;
        mem_rvalid    = 1'b0;
    endtask

    task automatic present(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                           input logic [DATA_W-1:0] i, input logic rw, input logic m2r);
        in_valid      = 1'b1;
        in_dest_addr  = a;
        in_alu_result = d;
        in_inst       = i;
        in_reg_write  = rw;
        in_mem_to_reg = m2r;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        present(3'd1, 16'h1111, 16'h2222, 1'b1, 1'b1);
        tick();
        checks++;
        if ({stall, wb_wr_en, fwd_valid, load_err, wb_address, wb_data, inst_out, retired_count} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%b/%b/%b/%b/%h/%h/%h/%h exp=all_zero",
                     stall, wb_wr_en, fwd_valid, load_err, wb_address, wb_data, inst_out, retired_count);
        end
        idle_inputs();
        rst = 1'b0;
        tick();
        checks++;
        if (wb_wr_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_write got=%b exp=0", wb_wr_en);
        end
    endtask

    task automatic test_alu_write();
        do_reset();
        present(3'd3, 16'h1234, 16'hA003, 1'b1, 1'b0);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL alu_stall got=%b exp=0", stall);
        end
        tick();
        idle_inputs();
        checks++;
        if ({wb_wr_en, wb_address, wb_data, inst_out} !== {1'b1, 3'd3, 16'h1234, 16'hA003}) begin
            failures++;
            $display("FAIL alu_commit got=%b/%h/%h/%h exp=1/3/1234/a003", wb_wr_en, wb_address, wb_data, inst_out);
        end
        tick();
        checks++;
        if (wb_wr_en !== 1'b0) begin
            failures++;
            $display("FAIL alu_one_cycle got=%b exp=0", wb_wr_en);
        end
    endtask

    task automatic test_load();
        do_reset();
        present(3'd5, 16'h0000, 16'hB005, 1'b1, 1'b1);
        #1;
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL load_accept_stall got=%b exp=1", stall);
        end
        tick();
        idle_inputs();
        for (int k = 1; k <= 3; k++) begin
            checks++;
            if ({stall, wb_wr_en} !== 2'b10) begin
                failures++;
                $display("FAIL load_wait_%0d got=stall%b/wr%b exp=stall1/wr0", k, stall, wb_wr_en);
            end
            if (k == 3) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 16'hBEEF;
            end
            tick();
        end
        idle_inputs();
        checks++;
        if ({stall, wb_wr_en, wb_address, wb_data, inst_out} !== {1'b0, 1'b1, 3'd5, 16'hBEEF, 16'hB005}) begin
            failures++;
            $display("FAIL load_commit got=%b/%b/%h/%h/%h exp=0/1/5/beef/b005",
                     stall, wb_wr_en, wb_address, wb_data, inst_out);
        end
        tick();
        checks++;
        if (wb_wr_en !== 1'b0) begin
            failures++;
            $display("FAIL load_one_cycle got=%b exp=0", wb_wr_en);
        end
    endtask

    task automatic test_timeout();
        int n;
        bit wr_seen;
        do_reset();
        present(3'd6, 16'h0000, 16'hC006, 1'b1, 1'b1);
        tick();
        idle_inputs();
        n = 0;
        wr_seen = 1'b0;
        while (stall && n < 40) begin
            if (wb_wr_en) wr_seen = 1'b1;
            n++;
            tick();
        end
        checks++;
        if (n != int'(TMO)) begin
            failures++;
            $display("FAIL timeout_stall_cycles got=%0d exp=%0d", n, TMO);
        end
        checks++;
        if ({load_err, wr_seen, wb_wr_en} !== 3'b100) begin
            failures++;
            $display("FAIL timeout_flags got=err%b/seen%b/wr%b exp=err1/seen0/wr0", load_err, wr_seen, wb_wr_en);
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 16'hDEAD;
        tick();
        idle_inputs();
        tick();
        checks++;
        if ({wb_wr_en, load_err, wb_data} !== {1'b0, 1'b1, 16'h0000}) begin
            failures++;
            $display("FAIL timeout_late_rvalid got=wr%b/err%b/%h exp=wr0/err1/0000", wb_wr_en, load_err, wb_data);
        end
    endtask

    task automatic test_timeout_race();
        do_reset();
        present(3'd2, 16'h0000, 16'hD002, 1'b1, 1'b1);
        tick();
        idle_inputs();
        repeat (TMO - 1) tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 16'h5A5A;
        tick();
        idle_inputs();
        checks++;
        if ({wb_wr_en, wb_address, wb_data, load_err} !== {1'b1, 3'd2, 16'h5A5A, 1'b0}) begin
            failures++;
            $display("FAIL timeout_race got=%b/%h/%h/err%b exp=1/2/5a5a/err0", wb_wr_en, wb_address, wb_data, load_err);
        end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] d;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            d = DATA_W'($urandom);
            present(ADDR_W'(i + 1), d, DATA_W'(16'hE000 + i), 1'b1, 1'b0);
            tick();
            checks++;
            if ({wb_wr_en, wb_address, wb_data} !== {1'b1, ADDR_W'(i + 1), d}) begin
                failures++;
                $display("FAIL b2b_commit_%0d got=%b/%h/%h exp=1/%h/%h", i, wb_wr_en, wb_address, wb_data, ADDR_W'(i + 1), d);
            end
        end
        idle_inputs();
        checks++;
        if (retired_count !== exp_count(3)) begin
            failures++;
            $display("FAIL b2b_retired got=%0d exp=%0d", retired_count, exp_count(3));
        end
        tick();
        checks++;
        if (wb_wr_en !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end got=%b exp=0", wb_wr_en);
        end
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        present(3'd7, 16'h1111, 16'hF007, 1'b1, 1'b0);
        tick();
        present(3'd4, 16'h0000, 16'hF004, 1'b1, 1'b1);
        tick();
        idle_inputs();
        tick();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({stall, wb_wr_en, fwd_valid, load_err, wb_address, wb_data, inst_out, retired_count} !== '0) begin
            failures++;
            $display("FAIL midload_reset got=%b/%b/%b/%b/%h/%h/%h/%h exp=all_zero",
                     stall, wb_wr_en, fwd_valid, load_err, wb_address, wb_data, inst_out, retired_count);
        end
        tick();
        rst = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 16'h7777;
        tick();
        idle_inputs();
        checks++;
        if ({wb_wr_en, wb_data, stall} !== {1'b0, 16'h0000, 1'b0}) begin
            failures++;
            $display("FAIL midload_stray_rvalid got=wr%b/%h/stall%b exp=wr0/0000/stall0", wb_wr_en, wb_data, stall);
        end
        tick();
        checks++;
        if (wb_wr_en !== 1'b0) begin
            failures++;
            $display("FAIL midload_no_write got=%b exp=0", wb_wr_en);
        end
    endtask

    // Random stream of ALU ops, non-writing retires, loads with random latency
    // (some beyond the timeout) and idle gaps with stray memory responses.
    task automatic test_random();
        int  exp_n;
        bit  exp_err;
        int  kind;
        int  dly;
        int  n;
        wr_t w;
        do_reset();
        obs_q.delete();
        exp_q.delete();
        exp_n   = 0;
        exp_err = 1'b0;
        mon_en  = 1'b1;
        for (int t = 0; t < 300; t++) begin
            kind = int'($urandom_range(0, 9));
            w.a  = ADDR_W'($urandom);
            w.d  = DATA_W'($urandom);
            w.i  = DATA_W'($urandom);
            if (kind == 0) begin
                idle_inputs();
                in_inst       = w.i;
                in_mem_to_reg = 1'($urandom);
                mem_rvalid    = 1'($urandom);
                mem_rdata     = w.d;
                tick();
            end else if (kind <= 4) begin
                present(w.a, w.d, w.i, 1'b1, 1'b0);
                mem_rvalid = 1'($urandom);
                mem_rdata  = DATA_W'($urandom);
                tick();
                exp_q.push_back(w);
                exp_n++;
            end else if (kind == 5) begin
                present(w.a, w.d, w.i, 1'b0, 1'($urandom));
                tick();
                exp_n++;
            end else begin
                dly = int'($urandom_range(0, 17));
                present(w.a, DATA_W'($urandom), w.i, 1'b1, 1'b1);
                tick();
                idle_inputs();
                if (dly < int'(TMO)) begin
                    repeat (dly) tick();
                    mem_rvalid = 1'b1;
                    mem_rdata  = w.d;
                    tick();
                    exp_q.push_back(w);
                    exp_n++;
                end else begin
                    repeat (TMO) tick();
                    exp_err = 1'b1;
                end
            end
        end
        idle_inputs();
        tick();
        tick();
        mon_en = 1'b0;
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL rand_write_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL rand_write_%0d got=%h/%h/%h exp=%h/%h/%h", i,
                         obs_q[i].a, obs_q[i].d, obs_q[i].i, exp_q[i].a, exp_q[i].d, exp_q[i].i);
            end
        end
        checks++;
        if (retired_count !== exp_count(exp_n)) begin
            failures++;
            $display("FAIL rand_retired got=%0d exp=%0d", retired_count, exp_count(exp_n));
        end
        checks++;
        if (load_err !== exp_err) begin
            failures++;
            $display("FAIL rand_load_err got=%b exp=%b", load_err, exp_err);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_alu_write();
        test_load();
        test_timeout();
        test_timeout_race();
        test_back_to_back();
        test_reset_mid_load();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
